// File: rtl/jk_bank_pkg.sv
// Shared definitions for the JK bank arbiter: op codes, FSM states and
// the JK transfer function used by both the flop cells and the response path.
package jk_bank_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    // Returns {J, K} for a command op.
    function automatic logic [1:0] op_to_jk(input logic [1:0] op);
        logic [1:0] jk;
        case (op)
            OP_RST:  jk = 2'b01;
            OP_SET:  jk = 2'b10;
            OP_TGL:  jk = 2'b11;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

    function automatic logic jk_next(input logic j, input logic k, input logic q);
        logic nq;
        case ({j, k})
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            2'b11:   nq = ~q;
            default: nq = q;
        endcase
        return nq;
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Request/response bundle between the requesters and the JK bank arbiter.
interface jk_bank_arbiter_if
    import jk_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) ();

    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_mask;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_q;

    modport master (
        output req_valid, req_op, req_mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_q
    );

    modport slave (
        input  req_valid, req_op, req_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_q
    );

endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop, asynchronously cleared by rst.
module jk_cell
    import jk_bank_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= jk_next(j, k, q);
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin sequencer owning a bank of JK flops: grants one masked
// SET/RESET/TOGGLE/HOLD command at a time and reports the updated bank.
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    jk_bank_arbiter_if.slave   bus,
    output logic [WIDTH-1:0]   q,
    output logic               busy
);

    localparam int IDW = id_width(NREQ);

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] rsp_q_r;

    logic [IDW:0]       start;
    logic [2*NREQ-1:0]  dbl_vld;
    logic [NREQ-1:0]    rot_vld;
    logic               grant_vld;
    logic [IDW-1:0]     grant_id;
    int                 gsum;
    logic [1:0]         sel_op;
    logic [WIDTH-1:0]   sel_mask;

    logic [1:0]       jk;
    logic [WIDTH-1:0] j_vec, k_vec, bank_next;

    // Rotate valids so bit 0 is the requester just after ptr; lowest set bit wins.
    always_comb begin
        start     = {1'b0, ptr} + 1'b1;
        dbl_vld   = {bus.req_valid, bus.req_valid};
        rot_vld   = NREQ'(dbl_vld >> start);
        grant_vld = 1'b0;
        grant_id  = '0;
        gsum      = 0;
        for (int n = NREQ - 1; n >= 0; n--) begin
            if (rot_vld[n]) begin
                grant_vld = 1'b1;
                gsum      = int'(start) + n;
                if (gsum >= NREQ) gsum -= NREQ;
                grant_id  = IDW'(gsum);
            end
        end
    end

    always_comb begin
        sel_op   = '0;
        sel_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_op   = bus.req_op[2*i +: 2];
                sel_mask = bus.req_mask[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == ST_IDLE && !rst && grant_vld)
            bus.req_ready = NREQ'(1) << grant_id;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (grant_vld) state_nxt = ST_APPLY;
            ST_APPLY:  state_nxt = ST_REPORT;
            ST_REPORT: if (bus.rsp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= IDW'(NREQ - 1);
            id_r    <= '0;
            rsp_q_r <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && grant_vld)
                id_r <= grant_id;
            if (state == ST_APPLY) begin
                ptr     <= id_r;
                rsp_q_r <= bank_next;
            end
        end
    end

    // Command payload is only consumed in APPLY, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && grant_vld) begin
            op_r   <= sel_op;
            mask_r <= sel_mask;
        end
    end

    always_comb begin
        jk    = op_to_jk(op_r);
        j_vec = '0;
        k_vec = '0;
        if (state == ST_APPLY) begin
            j_vec = mask_r & {WIDTH{jk[1]}};
            k_vec = mask_r & {WIDTH{jk[0]}};
        end
        for (int b = 0; b < WIDTH; b++)
            bank_next[b] = jk_next(j_vec[b], k_vec[b], q[b]);
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_vec[b]),
            .k   (k_vec[b]),
            .q   (q[b])
        );
    end

    assign bus.rsp_valid = (state == ST_REPORT);
    assign bus.rsp_id    = id_r;
    assign bus.rsp_q     = rsp_q_r;
    assign busy          = (state != ST_IDLE);

endmodule
